rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing one picture ROM port.
REQ-002 The block SHALL have parameter AW, default 17, meaning the ROM address width.
REQ-003 The block SHALL have parameter DW, default 16, meaning the ROM data width in RGB565.
REQ-004 The block SHALL have parameter ROM_LAT, default 1, meaning the cycles from rom_ena/rom_addr to valid rom_data.
REQ-005 vga_clk  input  1  25.175 MHz pixel clock; all logic rises on it.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 hold  input  1  when high, no new grants are issued (e.g. blanking or scene switch).
REQ-008 req  input  N_REQ  per-requester read request, level.
REQ-009 addr_i  input  N_REQ*AW  packed request addresses; requester i uses bits [i*AW +: AW].
REQ-010 gnt  output  N_REQ  registered one-hot grant, asserted for one cycle per accepted read.
REQ-011 rom_ena  output  1  ROM enable.
REQ-012 rom_addr  output  AW  ROM address.
REQ-013 rom_data  input  DW  ROM read data.
REQ-014 rd_valid  output  1  rd_data and rd_id are valid this cycle.
REQ-015 rd_id  output  log2(N_REQ)  index of the requester owning rd_data.
REQ-016 rd_data  output  DW  rom_data passed through combinationally.

Function
REQ-017 The arbiter SHALL sample req in cycle t and, with hold low and req nonzero, assert gnt[i], rom_ena=1 and rom_addr=addr_i[i] in cycle t+1.
REQ-018 Selection SHALL be round-robin: search starts at pointer ptr and ascends modulo N_REQ; the first requesting index wins.
REQ-019 After granting i, ptr SHALL become (i+1) mod N_REQ; with no grant, ptr SHALL hold.
REQ-020 At most one gnt bit SHALL be high in any cycle, and one read SHALL be issued per cycle at most.
REQ-021 In cycles with no grant, rom_ena SHALL be 0 and rom_addr SHALL hold its last value.
REQ-022 rd_valid and rd_id SHALL follow rom_ena and the granted index through a ROM_LAT-deep shift pipeline; rd_valid is high exactly ROM_LAT cycles after each rom_ena pulse.
REQ-023 A requester SHALL hold req and addr stable until it sees gnt; dropping req before gnt withdraws the request with no side effect.
REQ-024 A requester keeping req high after gnt SHALL be treated as a new request; it wins back-to-back only if no other index requests.
REQ-025 hold SHALL block new grants only; reads already issued SHALL still produce rd_valid.
REQ-026 When hold deasserts, arbitration SHALL resume from the unchanged ptr.
REQ-027 If all N_REQ requesters request continuously, each SHALL be granted exactly once in every N_REQ consecutive grant cycles.

Reset
REQ-028 On rst: gnt=0, rom_ena=0, rom_addr=0, ptr=0, and the rd_valid/rd_id pipeline is cleared, all immediately.
REQ-029 Reads in flight at rst SHALL be discarded; no rd_valid SHALL appear after rst until a new grant.
REQ-030 The first grant after rst release SHALL occur no earlier than the second vga_clk rising edge after release.

Structure
REQ-031 N_REQ, AW, DW, ROM_LAT and the requester-index width SHALL be constants in shared package vga_pkg.
REQ-032 Round-robin selection SHALL be one combinational sub-module rr_pick.
- rr_pick inputs: req, ptr.
- rr_pick outputs: one-hot winner, index, any.

Verification
REQ-033 Reset then req=4'b0001, addr0=17'h00100 -> gnt=0001 and rom_addr=17'h00100 at t+1; rd_valid=1, rd_id=0 at t+2.
REQ-034 req=4'b1111 held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,… with ptr starting 0; rd_id sequence 0,1,2,3,0,… delayed by ROM_LAT.
REQ-035 ptr=2, req=4'b0011 -> gnt=0001 first, then 0010.
REQ-036 req=4'b0101 with hold=1 for 5 cycles -> no gnt, rom_ena=0; after hold drops, gnt=0001 (ptr=0) next cycle.
REQ-037 Assert rst one cycle after a grant -> rd_valid stays 0 throughout, all outputs 0, and ptr restarts at 0.
REQ-038 Requester 3 drops req the cycle before its turn -> no gnt[3], and the next requester in order is granted instead.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared constants for the picture ROM arbiter: requester count, ROM geometry
// and the pipeline depth of the ROM read.
package vga_pkg;
  localparam int N_REQ   = 4;
  localparam int AW      = 17;
  localparam int DW      = 16;
  localparam int ROM_LAT = 1;
  localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
endpackage

// File: rtl/rom_arbiter_if.sv
// Requester/ROM bus of the picture ROM arbiter. The arbiter uses the slave
// modport; the requesters plus ROM side use master.
interface rom_arbiter_if #(
  parameter int N_REQ = vga_pkg::N_REQ,
  parameter int AW    = vga_pkg::AW,
  parameter int DW    = vga_pkg::DW,
  parameter int IDW   = vga_pkg::IDW
);
  // Handshake: a requester raises req[i] with addr_i slice i stable and keeps
  // both until it sees gnt[i] for one cycle; lowering req before that withdraws
  // the request. Read data returns with rd_valid and rd_id; there is no
  // back-pressure on the read return.
  logic              hold;
  logic [N_REQ-1:0]  req;
  logic [N_REQ*AW-1:0] addr_i;
  logic [N_REQ-1:0]  gnt;
  logic              rom_ena;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic              rd_valid;
  logic [IDW-1:0]    rd_id;
  logic [DW-1:0]     rd_data;

  modport slave (
    input  hold, req, addr_i, rom_data,
    output gnt, rom_ena, rom_addr, rd_valid, rd_id, rd_data
  );

  modport master (
    output hold, req, addr_i, rom_data,
    input  gnt, rom_ena, rom_addr, rd_valid, rd_id, rd_data
  );
endinterface

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting index at or above ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = vga_pkg::N_REQ,
  parameter int IW = vga_pkg::IDW
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] index,
  output logic          any
);
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction

  always_comb begin
    winner = '0;
    index  = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[wrap(int'(ptr) + i)]) begin
        any                          = 1'b1;
        index                        = wrap(int'(ptr) + i);
        winner[wrap(int'(ptr) + i)]  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rom_arbiter.sv
// Shares one picture ROM port among N_REQ requesters with round-robin grants
// and returns the read data tagged with the owner after ROM_LAT cycles.
module rom_arbiter #(
  parameter int N_REQ   = vga_pkg::N_REQ,
  parameter int AW      = vga_pkg::AW,
  parameter int DW      = vga_pkg::DW,
  parameter int ROM_LAT = vga_pkg::ROM_LAT,
  parameter int IW      = vga_pkg::IDW
) (
  input  logic              vga_clk,
  input  logic              rst,
  rom_arbiter_if.slave      bus,
  output logic [IW-1:0]     ptr
);
  logic [N_REQ-1:0] win;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             armed;
  logic             issue;
  logic [AW-1:0]    addr_arr [N_REQ];

  logic [N_REQ-1:0] gnt_q;
  logic             ena_q;
  logic [AW-1:0]    addr_q;
  logic [IW-1:0]    idx_q;
  logic [ROM_LAT-1:0] vld_pipe;
  logic [IW-1:0]    id_pipe [ROM_LAT];

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign addr_arr[g] = bus.addr_i[g*AW +: AW];
  end

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (win),
    .index  (win_idx),
    .any    (win_any)
  );

  // armed stays low for the first edge after reset release, so the earliest
  // grant lands on the second edge.
  assign issue = win_any & ~bus.hold & armed;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      ptr      <= '0;
      gnt_q    <= '0;
      ena_q    <= 1'b0;
      addr_q   <= '0;
      idx_q    <= '0;
      vld_pipe <= '0;
      for (int k = 0; k < ROM_LAT; k++) id_pipe[k] <= '0;
    end else begin
      armed <= 1'b1;
      ena_q <= issue;
      gnt_q <= issue ? win : '0;
      if (issue) begin
        addr_q <= addr_arr[win_idx];
        idx_q  <= win_idx;
        ptr    <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      vld_pipe[0] <= ena_q;
      id_pipe[0]  <= idx_q;
      for (int k = 1; k < ROM_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rom_ena  = ena_q;
  assign bus.rom_addr = addr_q;
  assign bus.rd_valid = vld_pipe[ROM_LAT-1];
  assign bus.rd_id    = id_pipe[ROM_LAT-1];
  assign bus.rd_data  = bus.rom_data;
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a cycle table of inputs and hand-computed
// outputs, a read-data scoreboard and a reset-during-read sequence.
module tb_rom_arbiter;
  import vga_pkg::*;

  localparam logic [AW-1:0] A0 = 17'h00100;
  localparam logic [AW-1:0] A1 = 17'h00200;
  localparam logic [AW-1:0] A2 = 17'h00300;
  localparam logic [AW-1:0] A3 = 17'h1ABCD;

  typedef struct {
    logic             hold;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             ena;
    logic [AW-1:0]    addr;
    logic             rv;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   ptr;
  } vec_t;

  logic             vga_clk = 1'b0;
  logic             rst = 1'b1;
  logic             hold = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [DW-1:0]    rom_q = '0;
  logic [IDW-1:0]   ptr;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vq[$];
  logic [DW-1:0] exp_q[$];

  rom_arbiter_if bus ();

  assign bus.hold     = hold;
  assign bus.req      = req;
  assign bus.addr_i   = {A3, A2, A1, A0};
  assign bus.rom_data = rom_q;

  rom_arbiter dut (
    .vga_clk (vga_clk),
    .rst     (rst),
    .bus     (bus),
    .ptr     (ptr)
  );

  always #20 vga_clk = ~vga_clk;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hA5A5;
  endfunction

  // Single-port ROM with one cycle of read latency.
  always @(posedge vga_clk) begin
    if (bus.rom_ena) rom_q <= rom_f(bus.rom_addr);
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic h, input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] g,
                     input logic e, input logic [AW-1:0] a, input logic v,
                     input logic [IDW-1:0] i, input logic [IDW-1:0] p);
    vec_t t;
    t.hold = h; t.req = r; t.gnt = g; t.ena = e; t.addr = a; t.rv = v; t.id = i; t.ptr = p;
    vq.push_back(t);
  endtask

  task automatic check_row(input int n, input vec_t v);
    chk($sformatf("r%0d_gnt", n), 32'(bus.gnt), 32'(v.gnt));
    chk($sformatf("r%0d_rom_ena", n), 32'(bus.rom_ena), 32'(v.ena));
    chk($sformatf("r%0d_rom_addr", n), 32'(bus.rom_addr), 32'(v.addr));
    chk($sformatf("r%0d_ptr", n), 32'(ptr), 32'(v.ptr));
    chk($sformatf("r%0d_rd_valid", n), 32'(bus.rd_valid), 32'(v.rv));
    if (v.rv) begin
      chk($sformatf("r%0d_rd_id", n), 32'(bus.rd_id), 32'(v.id));
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL r%0d_sb: rd_valid with no read expected", n);
      end else begin
        chk($sformatf("r%0d_rd_data", n), 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
    if (v.ena) exp_q.push_back(rom_f(v.addr));
  endtask

  initial begin
    //  hold req      gnt      ena  addr  rv   id     ptr
    add(1'b0, 4'b0001, 4'b0000, 1'b0, '0, 1'b0, 2'd0, 2'd0);
    add(1'b0, 4'b0001, 4'b0001, 1'b1, A0, 1'b0, 2'd0, 2'd1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, A0, 1'b1, 2'd0, 2'd1);
    add(1'b0, 4'b1000, 4'b1000, 1'b1, A3, 1'b0, 2'd0, 2'd0);
    add(1'b0, 4'b1111, 4'b0001, 1'b1, A0, 1'b1, 2'd3, 2'd1);
    add(1'b0, 4'b1111, 4'b0010, 1'b1, A1, 1'b1, 2'd0, 2'd2);
    add(1'b0, 4'b1111, 4'b0100, 1'b1, A2, 1'b1, 2'd1, 2'd3);
    add(1'b0, 4'b1111, 4'b1000, 1'b1, A3, 1'b1, 2'd2, 2'd0);
    add(1'b0, 4'b1111, 4'b0001, 1'b1, A0, 1'b1, 2'd3, 2'd1);
    add(1'b0, 4'b1111, 4'b0010, 1'b1, A1, 1'b1, 2'd0, 2'd2);
    add(1'b0, 4'b1111, 4'b0100, 1'b1, A2, 1'b1, 2'd1, 2'd3);
    add(1'b0, 4'b1111, 4'b1000, 1'b1, A3, 1'b1, 2'd2, 2'd0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, A3, 1'b1, 2'd3, 2'd0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, A3, 1'b0, 2'd0, 2'd0);
    add(1'b0, 4'b0010, 4'b0010, 1'b1, A1, 1'b0, 2'd0, 2'd2);
    add(1'b0, 4'b0011, 4'b0001, 1'b1, A0, 1'b1, 2'd1, 2'd1);
    add(1'b0, 4'b0010, 4'b0010, 1'b1, A1, 1'b1, 2'd0, 2'd2);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, A1, 1'b1, 2'd1, 2'd2);
    add(1'b0, 4'b0100, 4'b0100, 1'b1, A2, 1'b0, 2'd0, 2'd3);
    add(1'b0, 4'b0100, 4'b0100, 1'b1, A2, 1'b1, 2'd2, 2'd3);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, A2, 1'b1, 2'd2, 2'd3);
    add(1'b0, 4'b1000, 4'b1000, 1'b1, A3, 1'b0, 2'd0, 2'd0);
    add(1'b1, 4'b0101, 4'b0000, 1'b0, A3, 1'b1, 2'd3, 2'd0);
    for (int k = 0; k < 4; k++)
      add(1'b1, 4'b0101, 4'b0000, 1'b0, A3, 1'b0, 2'd0, 2'd0);
    add(1'b0, 4'b0101, 4'b0001, 1'b1, A0, 1'b0, 2'd0, 2'd1);
    add(1'b0, 4'b1100, 4'b0100, 1'b1, A2, 1'b1, 2'd0, 2'd3);
    add(1'b0, 4'b0001, 4'b0001, 1'b1, A0, 1'b1, 2'd2, 2'd1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, A0, 1'b1, 2'd0, 2'd1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, A0, 1'b0, 2'd0, 2'd1);

    repeat (2) step();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_rom_ena", 32'(bus.rom_ena), 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_ptr", 32'(ptr), 32'h0);
    rst = 1'b0;

    for (int n = 0; n < vq.size(); n++) begin
      hold = vq[n].hold;
      req  = vq[n].req;
      step();
      check_row(n, vq[n]);
    end
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    // Reset lands while a granted read is in flight.
    req = 4'b0010;
    step();
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h2);
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(bus.gnt), 32'h0);
    chk("arst_rom_ena", 32'(bus.rom_ena), 32'h0);
    chk("arst_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("arst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("arst_ptr", 32'(ptr), 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("in_rst%0d_rd_valid", k), 32'(bus.rd_valid), 32'h0);
    end
    rst = 1'b0;
    req = 4'b0110;
    step();
    chk("rel1_gnt", 32'(bus.gnt), 32'h0);
    chk("rel1_rd_valid", 32'(bus.rd_valid), 32'h0);
    step();
    chk("rel2_gnt", 32'(bus.gnt), 32'h2);
    chk("rel2_rom_addr", 32'(bus.rom_addr), 32'(A1));
    chk("rel2_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rel2_ptr", 32'(ptr), 32'h2);
    req = 4'b0100;
    step();
    chk("rel3_gnt", 32'(bus.gnt), 32'h4);
    chk("rel3_rd_valid", 32'(bus.rd_valid), 32'h1);
    chk("rel3_rd_id", 32'(bus.rd_id), 32'h1);
    chk("rel3_rd_data", 32'(bus.rd_data), 32'(rom_f(A1)));
    req = 4'b0000;
    step();
    chk("rel4_gnt", 32'(bus.gnt), 32'h0);
    chk("rel4_rd_valid", 32'(bus.rd_valid), 32'h1);
    chk("rel4_rd_id", 32'(bus.rd_id), 32'h2);
    chk("rel4_rd_data", 32'(bus.rd_data), 32'(rom_f(A2)));
    step();
    chk("rel5_rd_valid", 32'(bus.rd_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
